// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and defaults for the round-robin hold arbiter slice.
//   arb_state_e      : arbiter FSM states (IDLE / GRANT / GAP)
//   ARB_N_REQ_DEF    : default number of requesters
//   ARB_MAX_HOLD_DEF : default maximum hold time in cycles (timeout build only)
//   arb_wrap_inc     : modulo-n increment used to rotate the priority pointer
// -----------------------------------------------------------------------------
package arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_GAP   = 2'd2
   } arb_state_e;

   localparam int ARB_N_REQ_DEF    = 4;
   localparam int ARB_MAX_HOLD_DEF = 16;

   // Returns (idx + 1) mod n for 0 <= idx < n.
   function automatic int arb_wrap_inc(input int idx, input int n);
      int nxt;
      nxt = idx + 1;
      if (nxt >= n) begin
         return 0;
      end else begin
         return nxt;
      end
   endfunction

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner search. Starting at index ptr and wrapping
// from N_REQ-1 back to 0, the first asserted request bit wins.
// Ports:
//   req     in  [N_REQ-1:0] request vector
//   ptr     in  [ID_W-1:0]  highest-priority index for this search
//   win     out [N_REQ-1:0] one-hot winner, all zeros when no request
//   win_id  out [ID_W-1:0]  index of the winner (0 when no request)
//   win_vld out             at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
   import arb_pkg::*;
#(
   parameter int N_REQ = ARB_N_REQ_DEF,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] win,
   output logic [ID_W-1:0]  win_id,
   output logic             win_vld
);

   logic [2*N_REQ-1:0] dbl_s;
   logic [N_REQ-1:0]   rot_s;
   int                 off_s;
   int                 sum_s;
   int                 id_s;

   // Rotate so ptr sits at bit 0, priority-encode the lowest set bit, then
   // map the offset back to an absolute requester index.
   always_comb begin
      dbl_s = {req, req} >> ptr;
      rot_s = dbl_s[N_REQ-1:0];

      // Scanning downward leaves the lowest set offset in off_s.
      off_s = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         off_s = rot_s[i] ? i : off_s;
      end

      sum_s = 32'(ptr) + off_s;
      if (sum_s >= N_REQ) begin
         id_s = sum_s - N_REQ;
      end else begin
         id_s = sum_s;
      end

      win_vld = |req;
      win_id  = win_vld ? ID_W'(id_s) : {ID_W{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         win[i] = win_vld && (id_s == i);
      end
   end

endmodule : rr_pick

// File: rtl/rr_hold_arbiter.sv
// -----------------------------------------------------------------------------
// rr_hold_arbiter
// Round-robin arbiter for one shared resource. A grant is held for a whole
// multi-cycle transaction, released on the owner's done pulse or request drop,
// followed by exactly one idle (GAP) cycle; priority then rotates past the
// last owner.
//
// Optional feature macro: ARB_HOLD_TIMEOUT_EN
//   defined   -> a grant is forcibly released after MAX_HOLD cycles and
//                timeout_evt pulses during the following GAP cycle
//   undefined -> no hold counter, grant held until done/req drop,
//                timeout_evt tied to 0
//
// Ports:
//   clk         in  [1]       rising-edge clock
//   rst         in  [1]       asynchronous active-high reset
//   req         in  [N_REQ]   per-requester level request
//   done        in  [N_REQ]   end-of-transaction pulse (owner bit only)
//   grant       out [N_REQ]   registered one-hot grant, 0 when no owner
//   grant_id    out [ID_W]    registered owner index, valid while busy=1
//   busy        out [1]       registered, equals |grant
//   timeout_evt out [1]       registered 1-cycle pulse on forced release
// -----------------------------------------------------------------------------
module rr_hold_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ    = ARB_N_REQ_DEF,
   parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
   parameter int ID_W     = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             busy,
   output logic             timeout_evt
);

   // Elaboration-time guard on illegal configurations.
   if (N_REQ < 2 || MAX_HOLD < 2 || ID_W != $clog2(N_REQ)) begin : g_bad_cfg
      $error("rr_hold_arbiter: N_REQ>=2, MAX_HOLD>=2 and ID_W=$clog2(N_REQ) required");
   end

   arb_state_e       state_r;
   logic [ID_W-1:0]  ptr_r;
   logic [N_REQ-1:0] grant_r;
   logic [ID_W-1:0]  grant_id_r;
   logic             busy_r;
   logic             timeout_evt_r;

   logic [N_REQ-1:0] win_s;
   logic [ID_W-1:0]  win_id_s;
   logic             win_vld_s;
   logic             owner_req_s;
   logic             owner_done_s;
   logic             release_s;
   logic             force_s;
   logic [ID_W-1:0]  next_ptr_s;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req     (req),
      .ptr     (ptr_r),
      .win     (win_s),
      .win_id  (win_id_s),
      .win_vld (win_vld_s)
   );

   // Normal release: only the current owner's req/done bits matter, and a
   // simultaneous req drop plus done still yields a single release.
   always_comb begin
      owner_req_s  = req[grant_id_r];
      owner_done_s = done[grant_id_r];
      release_s    = (state_r == ARB_GRANT) && (!owner_req_s || owner_done_s);
      next_ptr_s   = ID_W'(arb_wrap_inc(int'(grant_id_r), N_REQ));
   end

`ifdef ARB_HOLD_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD);

   logic [CNT_W-1:0] hold_cnt_r;

   // Forced release fires on the last allowed hold cycle unless a normal
   // release already happens on the same edge.
   always_comb begin
      force_s = (state_r == ARB_GRANT) && !release_s &&
                (hold_cnt_r == CNT_W'(MAX_HOLD - 1));
   end

   // Hold counter: zero outside GRANT so it starts at 0 on every GRANT entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r != ARB_GRANT) begin
         hold_cnt_r <= {CNT_W{1'b0}};
      end else begin
         hold_cnt_r <= hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end
`else
   // No timeout in this build: a grant is only ended by its owner.
   always_comb begin
      force_s = 1'b0;
   end
`endif

   // Arbiter FSM, priority pointer and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ARB_IDLE;
         ptr_r         <= {ID_W{1'b0}};
         grant_r       <= {N_REQ{1'b0}};
         grant_id_r    <= {ID_W{1'b0}};
         busy_r        <= 1'b0;
         timeout_evt_r <= 1'b0;
      end else begin
         timeout_evt_r <= 1'b0;
         case (state_r)
            ARB_IDLE, ARB_GAP: begin
               // Arbitrate from ptr; GAP already sees the rotated pointer.
               if (win_vld_s) begin
                  state_r    <= ARB_GRANT;
                  grant_r    <= win_s;
                  grant_id_r <= win_id_s;
                  busy_r     <= 1'b1;
               end else begin
                  state_r    <= ARB_IDLE;
                  grant_r    <= {N_REQ{1'b0}};
                  busy_r     <= 1'b0;
               end
            end
            ARB_GRANT: begin
               if (release_s || force_s) begin
                  state_r       <= ARB_GAP;
                  grant_r       <= {N_REQ{1'b0}};
                  busy_r        <= 1'b0;
                  ptr_r         <= next_ptr_s;
                  timeout_evt_r <= force_s;
               end else begin
                  state_r       <= ARB_GRANT;
               end
            end
            default: begin
               state_r    <= ARB_IDLE;
               grant_r    <= {N_REQ{1'b0}};
               grant_id_r <= {ID_W{1'b0}};
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign grant       = grant_r;
   assign grant_id    = grant_id_r;
   assign busy        = busy_r;
   assign timeout_evt = timeout_evt_r;

endmodule : rr_hold_arbiter

// File: tb/tb_rr_hold_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_hold_arbiter
// Directed, self-checking bench for rr_hold_arbiter (N_REQ=4). Outputs are
// sampled 1 time unit after the rising edge. With ARB_HOLD_TIMEOUT_EN defined
// the DUT is built with MAX_HOLD=4 and the forced-release path is exercised.
// -----------------------------------------------------------------------------
module tb_rr_hold_arbiter;

`ifdef ARB_HOLD_TIMEOUT_EN
   localparam int MH = 4;
`else
   localparam int MH = 16;
`endif

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       busy;
   logic       timeout_evt;

   int checks;
   int errors;

   rr_hold_arbiter #(
      .N_REQ    (4),
      .MAX_HOLD (MH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_evt (timeout_evt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Checks grant, busy and (when busy) grant_id together.
   task automatic chk_grant(input string tag, input logic [3:0] exp_g, input int exp_id);
      chk({tag, ".grant"}, 32'(grant), 32'(exp_g));
      chk({tag, ".busy"}, 32'(busy), 32'(exp_g != 4'b0000));
      if (exp_g != 4'b0000) begin
         chk({tag, ".grant_id"}, 32'(grant_id), 32'(exp_id));
      end else begin
         chk({tag, ".timeout_evt"}, 32'(timeout_evt), 32'(0));
      end
   endtask

   initial begin
      logic [3:0] oh;
      logic [3:0] nxt;
      checks = 0;
      errors = 0;
      rst  = 1'b1;
      req  = 4'b0000;
      done = 4'b0000;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.grant", 32'(grant), 32'(0));
      chk("rst.grant_id", 32'(grant_id), 32'(0));
      chk("rst.busy", 32'(busy), 32'(0));
      chk("rst.timeout_evt", 32'(timeout_evt), 32'(0));
      rst = 1'b0;
      step();
      chk_grant("idle", 4'b0000, 0);

      // First grant one cycle after req is sampled, then async reset mid-grant
      req = 4'b1111;
      step();
      chk_grant("first", 4'b0001, 0);
      step();
      chk_grant("held", 4'b0001, 0);
      rst = 1'b1;
      #1;
      chk("async_rst.grant", 32'(grant), 32'(0));
      chk("async_rst.busy", 32'(busy), 32'(0));
      #1;
      rst = 1'b0;
      step();
      chk_grant("post_rst", 4'b0001, 0);

      // Fairness: each owner pulses done in its first grant cycle
      for (int i = 0; i < 4; i++) begin
         oh   = 4'b0001 << i;
         nxt  = (i == 3) ? 4'b0001 : (oh << 1);
         done = oh;
         step();
         chk_grant("fair.gap", 4'b0000, 0);
         done = 4'b0000;
         step();
         chk_grant("fair.next", nxt, (i + 1) % 4);
      end

      // Drain to IDLE
      req = 4'b0000;
      step();
      chk_grant("drain.gap", 4'b0000, 0);
      step();
      chk_grant("drain.idle", 4'b0000, 0);

      // Hold: req[2] alone for 5 cycles, then done and req drop together
      req = 4'b0100;
      step();
      chk_grant("hold.c1", 4'b0100, 2);
      for (int k = 2; k <= 5; k++) begin
         step();
         chk_grant("hold.cn", 4'b0100, 2);
      end
      done = 4'b0100;
      req  = 4'b0000;
      step();
      chk_grant("hold.gap", 4'b0000, 0);
      done = 4'b0000;
      step();
      chk_grant("hold.idle", 4'b0000, 0);
      // ptr is now 3: full request set must pick requester 3
      req = 4'b1111;
      step();
      chk_grant("hold.ptr3", 4'b1000, 3);

      // Re-grant: owner 3 drops, only requester 1 remains
      req = 4'b0010;
      step();
      chk_grant("regrant.gap0", 4'b0000, 0);
      step();
      chk_grant("regrant.g1", 4'b0010, 1);
      done = 4'b0010;
      step();
      chk_grant("regrant.gap1", 4'b0000, 0);
      done = 4'b0000;
      step();
      chk_grant("regrant.self", 4'b0010, 1);
      req  = 4'b1010;
      done = 4'b0010;
      step();
      chk_grant("regrant.gap2", 4'b0000, 0);
      done = 4'b0000;
      step();
      chk_grant("regrant.r3", 4'b1000, 3);

      // Noise on non-owner bits while requester 1 owns the grant
      req = 4'b0010;
      step();
      chk_grant("noise.gap", 4'b0000, 0);
      step();
      chk_grant("noise.own", 4'b0010, 1);
      done = 4'b0001;
      step();
      chk_grant("noise.done0", 4'b0010, 1);
      done = 4'b0000;
      req  = 4'b1010;
      step();
      chk_grant("noise.req3_hi", 4'b0010, 1);
      req = 4'b0010;
      step();
      chk_grant("noise.req3_lo", 4'b0010, 1);
      req  = 4'b1010;
      done = 4'b1101;
      step();
      chk_grant("noise.mixed", 4'b0010, 1);
      req  = 4'b0010;
      done = 4'b0010;
      step();
      chk_grant("noise.release", 4'b0000, 0);
      req  = 4'b0000;
      done = 4'b0000;
      step();
      chk_grant("noise.idle", 4'b0000, 0);

`ifdef ARB_HOLD_TIMEOUT_EN
      // Forced release after MAX_HOLD=4 cycles
      req = 4'b0001;
      step();
      chk_grant("to.c1", 4'b0001, 0);
      chk("to.evt_c1", 32'(timeout_evt), 32'(0));
      for (int k = 2; k <= 4; k++) begin
         step();
         chk_grant("to.cn", 4'b0001, 0);
         chk("to.evt_cn", 32'(timeout_evt), 32'(0));
      end
      req = 4'b0011;
      step();
      chk("to.gap.grant", 32'(grant), 32'(0));
      chk("to.gap.busy", 32'(busy), 32'(0));
      chk("to.gap.evt", 32'(timeout_evt), 32'(1));
      step();
      chk_grant("to.next", 4'b0010, 1);
      chk("to.evt_clear", 32'(timeout_evt), 32'(0));
`else
      // No timeout build: grant held indefinitely, timeout_evt stays 0
      req = 4'b0001;
      for (int k = 0; k < 20; k++) begin
         step();
         chk_grant("notimeout.hold", 4'b0001, 0);
         chk("notimeout.evt", 32'(timeout_evt), 32'(0));
      end
      req = 4'b0000;
      step();
      chk_grant("notimeout.release", 4'b0000, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_rr_hold_arbiter

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- 4-way round-robin arbiter for one shared resource (bus or port).
- A grant is held across a multi-cycle transaction until the owner signals done or drops its request.
- After each transaction there is one guaranteed idle cycle, and priority rotates past the last owner.
- Downstream mux selects on grant_id; the existing arbiter assertion set (reset, one-hot, no grant without request, no back-to-back regrant) must hold on this block.

Parameters:
- N_REQ, 4, number of requesters; must be ≥2.
- MAX_HOLD, 16, maximum cycles a grant may be held; used only when the timeout feature is compiled in; must be ≥2.
- ID_W, $clog2(N_REQ), width of grant_id (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request, level; held high for the whole transaction.
- done  input  N_REQ  per-requester end-of-transaction pulse; sampled only on the current owner's bit.
- grant  output  N_REQ  registered one-hot grant; all zeros when no owner.
- grant_id  output  ID_W  registered index of the owner; valid only while busy=1.
- busy  output  1  registered; equals |grant.
- timeout_evt  output  1  registered 1-cycle pulse on forced release; tied 0 when the feature is compiled out.

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - grant=0, grant_id=0, busy=0, timeout_evt=0.
  - Priority pointer ptr=0; state=IDLE; hold counter=0.
- Three states: IDLE, GRANT, GAP.
- Arbitration:
  - Combinational search from ptr upward, wrapping at N_REQ-1→0.
  - The first set req bit wins.
  - Evaluated only in IDLE and GAP.
- IDLE: if |req, go to GRANT; grant/grant_id/busy load the winner on the next edge (1-cycle req→grant latency). Otherwise stay in IDLE.
- GRANT (owner g):
  - Grant held while req[g]=1 and done[g]=0.
  - Release condition is req[g]=0 or done[g]=1, sampled at a clock edge. On release:
    - grant clears on that edge.
    - ptr becomes (g+1) mod N_REQ.
    - state goes to GAP.
  - If req and done drop/assert in the same cycle, only one release occurs.
  - done bits of non-owners are ignored in all states.
  - req changes on non-owners do not affect the current grant.
- GAP:
  - grant=0 for exactly one cycle.
  - Arbitration runs using the updated ptr. If |req, go to GRANT (new grant visible the cycle after GAP); otherwise go to IDLE.
  - The previous owner can win again only if no other requester is active.
- Invariants:
  - grant is always 0 or one-hot.
  - No grant is issued to a requester whose req was low at the arbitration edge.
- Worst-case wait with MAX_HOLD enforced: (N_REQ-1)·(MAX_HOLD+1)+2 cycles.

Optional Feature:
- Macro: ARB_HOLD_TIMEOUT_EN.
- Defined:
  - A hold counter resets to 0 on entry to GRANT and increments each GRANT cycle.
  - When the counter = MAX_HOLD-1 and no normal release occurs, release is forced: same transition as a normal release, and timeout_evt=1 during the first GAP cycle.
  - A normal release in the same cycle takes precedence; timeout_evt stays 0.
- Undefined:
  - No counter logic.
  - Grant is held indefinitely until done or req drop.
  - timeout_evt is constant 0.

Decomposition:
- Package arb_pkg:
  - typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_GRANT, ARB_GAP}.
  - localparam default N_REQ=4, MAX_HOLD=16.
- Sub-module rr_pick (combinational):
  - Inputs: req, ptr.
  - Outputs: one-hot win, win_id, win_vld.
  - Implements the rotate / priority-encode / rotate-back search.
- The top module holds the FSM, pointer, output registers and optional counter.

Test Plan:
- Reset: assert rst mid-grant with req=4'b1111 → grant=0, busy=0 immediately; after release, first grant=4'b0001 one cycle after req is sampled.
- Fairness: req=4'b1111 constant, each owner pulses done in its first grant cycle → grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- Hold: req[2] alone, done[2] after 5 cycles → grant=4'b0100 for 5 cycles, then 0, then IDLE; ptr=3.
- Re-grant: req=4'b0010 only, done each time → 0010,0000,0010 (self re-grant allowed when no other requester is active); add req[3] → next grant after GAP is 1000.
- Noise: done[0] pulsed while owner=1; req[3] toggled while owner=1 → grant stays 4'b0010 unchanged.
- Timeout (ARB_HOLD_TIMEOUT_EN, MAX_HOLD=4): req[0] held, no done → grant=0001 for exactly 4 cycles, then timeout_evt=1 in GAP. With req=4'b0011, the next grant is 0010.
